// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//
// Turns a stream of decoded-control requests back into 19-bit instruction
// words and writes them, one at a time, into an instruction memory starting
// at address 0. Illegal control combinations are dropped and counted.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   start                      begin a new program load (IDLE/DONE only)
//   in_valid / in_ready        request handshake
//   in_last                    request is the final word of the program
//   alu_op, alu_src, reg_write,
//   mem_read, mem_write,
//   mem_to_reg, rd, rs1, rs2,
//   imm                        request fields
//   imem_we, imem_addr,
//   imem_wdata                 instruction-memory write port
//   err                        one-cycle pulse: a request was illegal
//   err_count                  illegal requests since start (saturating)
//   done                       program load complete (level)
//   word_count                 words written since start
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | after reset, waiting for start
// ACCEPT | in_ready high, waiting for a request
// WRITE  | one-cycle memory write of the captured word
// DONE   | load finished, waiting for start
// ---------------------------------------------------------------------------
module instr_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [3:0]        alu_op,
    input  logic              alu_src,
    input  logic              reg_write,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              mem_to_reg,
    input  logic [2:0]        rd,
    input  logic [2:0]        rs1,
    input  logic [2:0]        rs2,
    input  logic [7:0]        imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [18:0]       imem_wdata,
    output logic              err,
    output logic [7:0]        err_count,
    output logic              done,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_WRITE  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic        last_q;
    logic        accept;
    logic        clr;
    logic        addr_full;

    logic [4:0]  ctl;
    logic        enc_legal;
    logic        enc_imm_fmt;
    logic        enc_nop;
    logic [4:0]  enc_opcode;
    logic [18:0] enc_word;

    // Control tuple ordered {alu_src, reg_write, mem_read, mem_write, mem_to_reg}
    assign ctl = {alu_src, reg_write, mem_read, mem_write, mem_to_reg};

    always_comb begin
        enc_legal   = 1'b0;
        enc_imm_fmt = 1'b0;
        enc_nop     = 1'b0;
        enc_opcode  = 5'd0;
        case (ctl)
            5'b01000: begin                     // R-type ALU
                if (!alu_op[3]) begin
                    enc_legal  = 1'b1;
                    enc_opcode = {1'b0, alu_op};
                end
            end
            5'b11000: begin                     // I-type ALU, only ops 0/1
                if (alu_op[3:1] == 3'd0) begin
                    enc_legal   = 1'b1;
                    enc_imm_fmt = 1'b1;
                    enc_opcode  = {4'b0100, alu_op[0]};
                end
            end
            5'b11101: begin                     // load
                if (alu_op == 4'd0) begin
                    enc_legal   = 1'b1;
                    enc_imm_fmt = 1'b1;
                    enc_opcode  = 5'b01010;
                end
            end
            5'b10010: begin                     // store
                if (alu_op == 4'd0) begin
                    enc_legal   = 1'b1;
                    enc_imm_fmt = 1'b1;
                    enc_opcode  = 5'b01011;
                end
            end
            5'b00000: begin                     // NOP
                if (alu_op == 4'd0) begin
                    enc_legal  = 1'b1;
                    enc_nop    = 1'b1;
                    enc_opcode = 5'b11111;
                end
            end
            default: ;
        endcase
    end

    // NOP carries no operand fields even if the request drives them.
    always_comb begin
        if (enc_nop) begin
            enc_word = {enc_opcode, 14'd0};
        end else if (enc_imm_fmt) begin
            enc_word = {enc_opcode, rd, rs1, imm};
        end else begin
            enc_word = {enc_opcode, rd, rs1, rs2, 5'd0};
        end
    end

    // Last address reached: the load stops here instead of wrapping.
    assign addr_full = &imem_addr;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        clr     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ACCEPT;
                    clr     = 1'b1;
                end
            end
            S_ACCEPT: begin
                if (in_valid) begin
                    accept = 1'b1;
                    if (enc_legal) begin
                        state_d = S_WRITE;
                    end else if (in_last) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_WRITE: begin
                if (last_q || addr_full) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ACCEPT;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d = S_ACCEPT;
                    clr     = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == S_ACCEPT);
        imem_we  = (state_q == S_WRITE);
        done     = (state_q == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            last_q     <= 1'b0;
            err        <= 1'b0;
            err_count  <= 8'd0;
            imem_addr  <= '0;
            imem_wdata <= 19'd0;
            word_count <= '0;
        end else begin
            state_q <= state_d;
            err     <= 1'b0;
            if (clr) begin
                imem_addr  <= '0;
                word_count <= '0;
                err_count  <= 8'd0;
            end
            if (accept) begin
                if (enc_legal) begin
                    imem_wdata <= enc_word;
                    last_q     <= in_last;
                end else begin
                    err <= 1'b1;
                    if (err_count != 8'hFF) begin
                        err_count <= err_count + 8'd1;
                    end
                end
            end
            if (state_q == S_WRITE) begin
                word_count <= word_count + (ADDR_W+1)'(1);
                if (!addr_full) begin
                    imem_addr <= imem_addr + ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Two encoders share one stimulus stream: dut_a (ADDR_W=8) and dut_b
// (ADDR_W=2, 4-word capacity). A transaction-level model tracks each one and
// every output is compared on every falling edge; directed sequences and an
// encoding table add constant expectations on top.
module tb_instr_encoder;

    logic        clk;
    logic        rst, start, in_valid, in_last;
    logic [3:0]  alu_op;
    logic        alu_src, reg_write, mem_read, mem_write, mem_to_reg;
    logic [2:0]  rd, rs1, rs2;
    logic [7:0]  imm;

    logic        in_ready_a, imem_we_a, err_a, done_a;
    logic [7:0]  imem_addr_a, err_count_a;
    logic [18:0] imem_wdata_a;
    logic [8:0]  word_count_a;

    logic        in_ready_b, imem_we_b, err_b, done_b;
    logic [1:0]  imem_addr_b;
    logic [7:0]  err_count_b;
    logic [18:0] imem_wdata_b;
    logic [2:0]  word_count_b;

    int total = 0;
    int bad   = 0;

    instr_encoder #(.ADDR_W(8)) dut_a (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_ready(in_ready_a), .in_last(in_last), .alu_op(alu_op),
        .alu_src(alu_src), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .rd(rd), .rs1(rs1),
        .rs2(rs2), .imm(imm), .imem_we(imem_we_a), .imem_addr(imem_addr_a),
        .imem_wdata(imem_wdata_a), .err(err_a), .err_count(err_count_a),
        .done(done_a), .word_count(word_count_a)
    );

    instr_encoder #(.ADDR_W(2)) dut_b (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_ready(in_ready_b), .in_last(in_last), .alu_op(alu_op),
        .alu_src(alu_src), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .rd(rd), .rs1(rs1),
        .rs2(rs2), .imm(imm), .imem_we(imem_we_b), .imem_addr(imem_addr_b),
        .imem_wdata(imem_wdata_b), .err(err_b), .err_count(err_count_b),
        .done(done_b), .word_count(word_count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void ref_encode(input logic [3:0] op, input logic src, rw, mr, mw, m2r,
                                       input logic [2:0] f_rd, f_rs1, f_rs2, input logic [7:0] f_imm,
                                       output bit legal, output logic [18:0] w);
        int opc;
        bit imm_fmt;
        legal   = 1'b1;
        imm_fmt = 1'b1;
        opc     = 0;
        w       = 19'd0;
        if (rw && !src && !mr && !mw && !m2r && op < 8) begin
            opc = int'(op);
            imm_fmt = 1'b0;
        end else if (rw && src && !mr && !mw && !m2r && op < 2) begin
            opc = 8 + int'(op);
        end else if (rw && src && mr && m2r && !mw && op == 0) begin
            opc = 10;
        end else if (!rw && src && mw && !mr && !m2r && op == 0) begin
            opc = 11;
        end else if (!rw && !src && !mr && !mw && !m2r && op == 0) begin
            w = 19'h7C000;
            return;
        end else begin
            legal = 1'b0;
            return;
        end
        w = 19'(opc * 16384 + int'(f_rd) * 2048 + int'(f_rs1) * 256 +
                (imm_fmt ? int'(f_imm) : int'(f_rs2) * 32));
    endfunction

    typedef struct {
        bit          active;   // a load is in progress
        bit          pend;     // an accepted word is being written this cycle
        bit          fin;
        bit          last;
        bit          err;
        int          addr;
        int          wc;
        int          ec;
        logic [18:0] wdata;
    } mdl_t;

    mdl_t m_a = '{default: 0};
    mdl_t m_b = '{default: 0};

    function automatic mdl_t step(input mdl_t m, input int cap);
        mdl_t n;
        bit lg;
        logic [18:0] w;
        n = m;
        n.err = 1'b0;
        if (rst) begin
            n = '{default: 0};
        end else if (m.pend) begin
            n.pend = 1'b0;
            n.wc = m.wc + 1;
            if (m.last || m.addr == cap - 1) begin
                n.fin = 1'b1;
                n.active = 1'b0;
            end
            if (m.addr < cap - 1) n.addr = m.addr + 1;
        end else if (m.active) begin
            if (in_valid) begin
                ref_encode(alu_op, alu_src, reg_write, mem_read, mem_write, mem_to_reg,
                           rd, rs1, rs2, imm, lg, w);
                if (lg) begin
                    n.pend = 1'b1;
                    n.wdata = w;
                    n.last = in_last;
                end else begin
                    n.err = 1'b1;
                    n.ec = (m.ec < 255) ? m.ec + 1 : 255;
                    if (in_last) begin
                        n.fin = 1'b1;
                        n.active = 1'b0;
                    end
                end
            end
        end else if (start) begin
            n.active = 1'b1;
            n.fin = 1'b0;
            n.addr = 0;
            n.wc = 0;
            n.ec = 0;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m_a <= step(m_a, 256);
        m_b <= step(m_b, 4);
    end

    always @(negedge clk) begin
        cmp("a.in_ready",   32'(in_ready_a),   32'(m_a.active && !m_a.pend));
        cmp("a.imem_we",    32'(imem_we_a),    32'(m_a.pend));
        cmp("a.err",        32'(err_a),        32'(m_a.err));
        cmp("a.done",       32'(done_a),       32'(m_a.fin));
        cmp("a.imem_addr",  32'(imem_addr_a),  32'(m_a.addr));
        cmp("a.imem_wdata", 32'(imem_wdata_a), 32'(m_a.wdata));
        cmp("a.err_count",  32'(err_count_a),  32'(m_a.ec));
        cmp("a.word_count", 32'(word_count_a), 32'(m_a.wc));
        cmp("b.in_ready",   32'(in_ready_b),   32'(m_b.active && !m_b.pend));
        cmp("b.imem_we",    32'(imem_we_b),    32'(m_b.pend));
        cmp("b.err",        32'(err_b),        32'(m_b.err));
        cmp("b.done",       32'(done_b),       32'(m_b.fin));
        cmp("b.imem_addr",  32'(imem_addr_b),  32'(m_b.addr));
        cmp("b.imem_wdata", 32'(imem_wdata_b), 32'(m_b.wdata));
        cmp("b.err_count",  32'(err_count_b),  32'(m_b.ec));
        cmp("b.word_count", 32'(word_count_b), 32'(m_b.wc));
    end

    // ---------------- encoding table ----------------
    typedef struct {
        logic [3:0]  op;
        logic        src, rw, mr, mw, m2r;
        logic [2:0]  f_rd, f_rs1, f_rs2;
        logic [7:0]  f_imm;
        bit          legal;
        logic [18:0] word;
    } vec_t;

    vec_t tbl[13];

    task automatic set_req(input vec_t v);
        alu_op = v.op; alu_src = v.src; reg_write = v.rw; mem_read = v.mr;
        mem_write = v.mw; mem_to_reg = v.m2r; rd = v.f_rd; rs1 = v.f_rs1;
        rs2 = v.f_rs2; imm = v.f_imm;
    endtask

    // Called at a falling edge with the encoder in ACCEPT; returns one
    // falling edge later, where the write strobe or err pulse is visible.
    task automatic send(input vec_t v, input bit last);
        set_req(v);
        in_valid = 1'b1;
        in_last  = last;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // alu_op=2 maps to opcode 00010, so ADD rd1,rs2,rs3 encodes as 19'h08A60.
        tbl[0]  = '{4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 3'd2, 3'd3, 8'h00, 1'b1, 19'h08A60};
        tbl[1]  = '{4'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd7, 3'd7, 3'd7, 8'hFF, 1'b1, 19'h1FFE0};
        tbl[2]  = '{4'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 3'd1, 3'd1, 8'h00, 1'b0, 19'h00000};
        tbl[3]  = '{4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 3'd4, 3'd0, 8'hA5, 1'b1, 19'h25CA5};
        tbl[4]  = '{4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd5, 8'h80, 1'b1, 19'h20080};
        tbl[5]  = '{4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 3'd1, 3'd1, 8'h11, 1'b0, 19'h00000};
        tbl[6]  = '{4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 3'd5, 3'd0, 8'h3C, 1'b1, 19'h2A53C};
        tbl[7]  = '{4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd6, 3'd7, 3'd0, 8'h01, 1'b1, 19'h2F701};
        tbl[8]  = '{4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 3'd3, 3'd2, 8'h55, 1'b1, 19'h7C000};
        tbl[9]  = '{4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 3'd1, 3'd1, 8'h00, 1'b0, 19'h00000};
        tbl[10] = '{4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 3'd1, 3'd1, 8'h00, 1'b0, 19'h00000};
        tbl[11] = '{4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 3'd1, 3'd1, 8'h00, 1'b0, 19'h00000};
        tbl[12] = '{4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 3'd1, 3'd1, 8'h00, 1'b0, 19'h00000};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        set_req(tbl[8]);

        // reset values
        @(negedge clk);
        cmp("rst.in_ready",   32'(in_ready_a),   0);
        cmp("rst.imem_we",    32'(imem_we_a),    0);
        cmp("rst.done",       32'(done_a),       0);
        cmp("rst.imem_wdata", 32'(imem_wdata_a), 0);
        cmp("rst.word_count", 32'(word_count_a), 0);
        @(negedge clk);
        rst = 1'b0;

        // single ADD with in_last
        do_start();
        send(tbl[0], 1'b1);
        cmp("add.we",    32'(imem_we_a),    1);
        cmp("add.addr",  32'(imem_addr_a),  0);
        cmp("add.wdata", 32'(imem_wdata_a), 32'h08A60);
        @(negedge clk);
        cmp("add.done",  32'(done_a),       1);
        cmp("add.wc",    32'(word_count_a), 1);
        cmp("add.ready", 32'(in_ready_a),   0);

        // encoding table
        do_start();
        for (int i = 0; i < 13; i++) begin
            send(tbl[i], 1'b0);
            if (tbl[i].legal) begin
                cmp($sformatf("tbl%0d.we", i), 32'(imem_we_a), 1);
                cmp($sformatf("tbl%0d.wdata", i), 32'(imem_wdata_a), 32'(tbl[i].word));
            end else begin
                cmp($sformatf("tbl%0d.err", i), 32'(err_a), 1);
                cmp($sformatf("tbl%0d.we", i), 32'(imem_we_a), 0);
            end
            @(negedge clk);
        end
        cmp("tbl.err_count",  32'(err_count_a),  6);
        cmp("tbl.word_count", 32'(word_count_a), 7);

        // load then store at consecutive addresses
        do_reset();
        do_start();
        send(tbl[6], 1'b0);
        cmp("ld.addr",  32'(imem_addr_a),  0);
        cmp("ld.wdata", 32'(imem_wdata_a), 32'h2A53C);
        @(negedge clk);
        send(tbl[7], 1'b0);
        cmp("st.addr",  32'(imem_addr_a),  1);
        cmp("st.wdata", 32'(imem_wdata_a), 32'h2F701);
        @(negedge clk);

        // illegal mem_read without reg_write
        send(tbl[9], 1'b0);
        cmp("ill.err",   32'(err_a),       1);
        cmp("ill.ec",    32'(err_count_a), 1);
        cmp("ill.we",    32'(imem_we_a),   0);
        cmp("ill.ready", 32'(in_ready_a),  1);
        @(negedge clk);

        // start during ACCEPT is ignored; start after DONE clears counters
        do_start();
        cmp("ign.ready", 32'(in_ready_a),   1);
        cmp("ign.addr",  32'(imem_addr_a),  2);
        cmp("ign.wc",    32'(word_count_a), 2);
        send(tbl[0], 1'b1);
        cmp("ign.waddr", 32'(imem_addr_a),  2);
        @(negedge clk);
        cmp("ign.done",  32'(done_a),       1);
        cmp("ign.wc3",   32'(word_count_a), 3);
        do_start();
        cmp("rst2.done", 32'(done_a),       0);
        cmp("rst2.wc",   32'(word_count_a), 0);
        cmp("rst2.ec",   32'(err_count_a),  0);
        cmp("rst2.addr", 32'(imem_addr_a),  0);

        // capacity limit on the 4-word instance
        for (int i = 0; i < 4; i++) begin
            send(tbl[6], 1'b0);
            cmp($sformatf("cap%0d.we", i),   32'(imem_we_b),   1);
            cmp($sformatf("cap%0d.addr", i), 32'(imem_addr_b), 32'(i));
            @(negedge clk);
        end
        cmp("cap.done",   32'(done_b),       1);
        cmp("cap.ready",  32'(in_ready_b),   0);
        cmp("cap.wc",     32'(word_count_b), 4);
        cmp("cap.a_wc",   32'(word_count_a), 4);
        cmp("cap.a_done", 32'(done_a),       0);

        // reset during the write cycle
        send(tbl[6], 1'b0);
        cmp("rw.we_before", 32'(imem_we_a), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cmp("rw.we",    32'(imem_we_a),    0);
        cmp("rw.addr",  32'(imem_addr_a),  0);
        cmp("rw.wdata", 32'(imem_wdata_a), 0);
        cmp("rw.wc",    32'(word_count_a), 0);
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        cmp("rw.idle_ready", 32'(in_ready_a), 0);

        // randomized traffic, checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom % 64) == 0;
            start    = ($urandom % 8) == 0;
            in_valid = ($urandom % 5) < 3;
            in_last  = ($urandom % 10) == 0;
            rd  = 3'($urandom); rs1 = 3'($urandom); rs2 = 3'($urandom);
            imm = 8'($urandom);
            {alu_src, reg_write, mem_read, mem_write, mem_to_reg} = 5'b00000;
            case ($urandom % 6)
                0: begin alu_op = 4'($urandom); reg_write = 1'b1; end
                1: begin alu_op = 4'($urandom_range(0, 3)); alu_src = 1'b1; reg_write = 1'b1; end
                2: begin alu_op = 4'($urandom_range(0, 1));
                         {alu_src, reg_write, mem_read, mem_to_reg} = 4'b1111; end
                3: begin alu_op = 4'($urandom_range(0, 1)); alu_src = 1'b1; mem_write = 1'b1; end
                4: alu_op = 4'($urandom_range(0, 1));
                default: begin
                    alu_op = 4'($urandom);
                    {alu_src, reg_write, mem_read, mem_write, mem_to_reg} = 5'($urandom);
                end
            endcase
            @(negedge clk);
        end
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
